inst_fifo_writer: RTL

Host-side producer for the GPU instruction stream. Packs the host's instruction fields into the 82-bit instruction word and buffers the words in an internal FIFO. It exposes the FIFO read side (`fifo_data`, `fifo_empty`, `read_en`) to the GPU top level, where the main controller pops words and the decode block unpacks them combinationally. It is the writer end of the instruction-FIFO interface.

---
 rtl/inst_fifo_writer.sv | 87 ++++++++
 1 files changed

// File: rtl/inst_fifo_writer.sv
// Host-side instruction FIFO writer: packs host instruction fields into an
// 82-bit word and buffers it in a first-word-fall-through circular FIFO.
module inst_fifo_writer #(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [47:0]       coordinates,
  input  logic [3:0]        alpha_val,
  input  logic [1:0]        texture_code,
  input  logic [23:0]       color_code,
  input  logic              layer_num,
  input  logic              vertice_num,
  input  logic              inst_type,
  input  logic              fill_type,
  input  logic              flush,
  input  logic              read_en,
  output logic [81:0]       fifo_data,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [PTR_W:0]    count,
  output logic              overflow_err,
  output logic              underflow_err
);

  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [81:0]      mem [DEPTH];
  logic [PTR_W-1:0] wp, rp;
  logic [PTR_W:0]   count_q;
  logic             push, pop;
  logic [81:0]      word;

  // Handshake: a word transfers on any edge where cmd_valid && cmd_ready.
  // cmd_ready is decoded from registered count only, so a full FIFO refuses
  // a push even while a pop happens in the same cycle.
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);
  assign cmd_ready  = !fifo_full;
  assign count      = count_q;

  assign push = cmd_valid && cmd_ready;
  // A pop on an empty FIFO is ignored even if a push lands the same cycle.
  assign pop  = read_en && !fifo_empty;

  assign word = {inst_type, fill_type, vertice_num, layer_num,
                 texture_code, alpha_val, color_code, coordinates};

  assign fifo_data = fifo_empty ? '0 : mem[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp            <= '0;
      rp            <= '0;
      count_q       <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else if (flush) begin
      wp            <= '0;
      rp            <= '0;
      count_q       <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (push) wp <= wp + PTR_ONE;
      if (pop)  rp <= rp + PTR_ONE;
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      if (cmd_valid && fifo_full) overflow_err  <= 1'b1;
      if (read_en && fifo_empty)  underflow_err <= 1'b1;
    end
  end

  // Storage is never cleared; flush and reset only move the pointers.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem[wp] <= word;
  end

endmodule
